alu_bist: RTL and testbench
===========================

# alu_bist

Built-in self-test engine that drives the 32-bit combinational ALU and checks its results: it is the driver and checker on the ALU's operand/result interface. On a start pulse it generates pseudo-random operand pairs, cycles through the eight supported ALUctr opcodes and waits a programmable settle time. It then compares ALUout/Less/Zero against an internal reference model, counts mismatches and captures the first failure. It sits beside the ALU in the datapath test harness and lets silicon or FPGA builds self-check the ALU without a software bench.

## Interface
- NUM_VECTORS, 64, vectors per run (1..65535)
- SETTLE_CYCLES, 1, cycles between driving operands and sampling results (1..15)
- SEED, 32'hACE1_2024, LFSR seed loaded on every start (must be nonzero)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle run request, honoured only in IDLE or DONE
- alu_a  out  32  operand A to ALU
- alu_b  out  32  operand B to ALU
- alu_ctr  out  4  ALUctr to ALU
- alu_out  in  32  ALUout from ALU
- alu_less  in  1  Less from ALU
- alu_zero  in  1  Zero from ALU
- busy  out  1  run in progress
- done  out  1  run finished; held until next start or reset
- pass  out  1  valid with done: 1 when err_count==0
- err_count  out  16  mismatching vectors, saturates at 16'hFFFF
- fail_idx  out  16  index of first failing vector
- fail_exp  out  32  expected ALUout of first failure
- fail_got  out  32  observed ALUout of first failure

## Operation
- FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE/DONE + start: load LFSR=SEED, clear vec index, err_count, fail_* and the first-fail flag; go to DRIVE.
- DRIVE: LFSR steps twice. alu_a is the value after the first step and alu_b the value after the second. alu_ctr = op_table[idx mod 8]; go to SETTLE.
- op_table order: 0000 add, 1000 sub, 0001 sll, 0101 srl, 0100 xor, 0111 and, 0110 or, 0010 slt.
- LFSR: 32-bit Galois, right shift, XOR mask 32'h8020_0003 applied when the shifted-out bit is 1.
- Reference model: add/sub are mod 2^32. Shift amount is alu_b[4:0]; srl is logical. slt gives {31'b0, $signed(a)<$signed(b)}.
- Expected Zero = (expected ALUout==0) for every op. Expected Less = $signed(a)<$signed(b), compared only for op 0010.
- SETTLE: counter runs SETTLE_CYCLES cycles; alu_* stay stable. Then go to CHECK.
- CHECK: a mismatch is any compared field differing.
  - On a mismatch, err_count increments (saturating).
  - On the first mismatch, fail_idx/fail_exp/fail_got are captured.
  - If idx==NUM_VECTORS-1, go to DONE; otherwise increment idx and go to DRIVE.
- DONE: done=1, pass=(err_count==0). Results hold until the next start.
- start in DRIVE/SETTLE/CHECK is ignored.

## Timing
- Reset values:
  - state IDLE; busy=0, done=0, pass=0.
  - alu_a=0, alu_b=0, alu_ctr=4'b0000.
  - err_count=0, fail_idx=0, fail_exp=0, fail_got=0.
- Reset mid-run aborts immediately to the reset values; no partial result is retained.
- start sampled high at edge 0 gives busy=1 from edge 1.
- alu_* are registered and change only on the DRIVE edge.
- Each vector takes 2+SETTLE_CYCLES cycles. DONE is entered (2+SETTLE_CYCLES)*NUM_VECTORS+1 edges after start; at that edge busy falls and done rises.
- All outputs are registered; no combinational path from alu_* inputs to outputs.

## Configuration
- ALU_BIST_STOP_ON_FAIL_EN defined: the first mismatch in CHECK goes directly to DONE with err_count=1. Later vectors are not run.
- ALU_BIST_STOP_ON_FAIL_EN undefined: all NUM_VECTORS run and err_count totals all mismatches.

## Test plan
- Golden ALU, NUM_VECTORS=8, SETTLE_CYCLES=1, start at edge 0 -> done=1 and busy=0 at edge 25; pass=1, err_count=0. alu_ctr sequence is 0000,1000,0001,0101,0100,0111,0110,0010.
- Golden ALU, ALUout bit 0 stuck at 0 injected, NUM_VECTORS=64 -> pass=0, err_count>0. fail_idx equals the first vector whose expected bit 0 is 1; fail_exp^fail_got=32'h1.
- Golden ALU with Less forced 0, NUM_VECTORS=8 -> mismatch only possible at idx 7. fail_idx=7 if $signed(a)<$signed(b) at idx 7, else pass=1.
- rst_n pulsed low at edge 10 of a run -> all outputs at reset values asynchronously. A new start then gives the identical alu_a/alu_b sequence from SEED.
- start held high for 3 cycles, then pulsed again mid-run -> only one run; idx sequence unaffected. start in DONE restarts with cleared err_count.
- ALU_BIST_STOP_ON_FAIL_EN defined, stuck-at fault at vector 2 -> DONE entered right after CHECK of idx 2; err_count=1, fail_idx=2.

Source files
------------

// File: rtl/alu_bist.sv
// alu_bist: LFSR-driven self-test engine for the 32-bit combinational ALU.
// Optional build macro: ALU_BIST_STOP_ON_FAIL_EN (end the run on the first mismatch).
module alu_bist #(
  parameter int unsigned NUM_VECTORS   = 64,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [31:0] SEED          = 32'hACE1_2024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctr,
  input  logic [31:0] alu_out,
  input  logic        alu_less,
  input  logic        alu_zero,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [15:0] fail_idx,
  output logic [31:0] fail_exp,
  output logic [31:0] fail_got
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);
  localparam logic [3:0]  SET_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_start;
  logic [31:0] r_lfsr;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [3:0]  r_ctr;
  logic [3:0]  r_cnt;
  logic [15:0] r_idx;
  logic [15:0] r_err;
  logic [15:0] r_fidx;
  logic [31:0] r_fexp;
  logic [31:0] r_fgot;
  logic        r_first;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;

  logic        w_idle_like;
  logic        w_load;
  logic [31:0] w_step1;
  logic [31:0] w_step2;
  logic [31:0] w_exp;
  logic        w_slt;
  logic        w_mis;
  logic [15:0] w_err_next;

  function automatic logic [31:0] f_step(input logic [31:0] x);
    f_step = {1'b0, x[31:1]} ^ (x[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [3:0] f_op(input logic [2:0] i);
    logic [3:0] op;
    op = 4'b0000;
    unique case (i)
      3'd0: op = 4'b0000;
      3'd1: op = 4'b1000;
      3'd2: op = 4'b0001;
      3'd3: op = 4'b0101;
      3'd4: op = 4'b0100;
      3'd5: op = 4'b0111;
      3'd6: op = 4'b0110;
      3'd7: op = 4'b0010;
      default: op = 4'b0000;
    endcase
    return op;
  endfunction

  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_load      = w_idle_like && r_start;
  assign w_step1     = f_step(r_lfsr);
  assign w_step2     = f_step(w_step1);
  assign w_slt       = $signed(r_a) < $signed(r_b);

  // Reference model of the ALU, driven from the registered operands
  always_comb begin
    w_exp = 32'h0;
    unique case (r_ctr)
      4'b0000: w_exp = r_a + r_b;
      4'b1000: w_exp = r_a - r_b;
      4'b0001: w_exp = r_a << r_b[4:0];
      4'b0101: w_exp = r_a >> r_b[4:0];
      4'b0100: w_exp = r_a ^ r_b;
      4'b0111: w_exp = r_a & r_b;
      4'b0110: w_exp = r_a | r_b;
      4'b0010: w_exp = {31'b0, w_slt};
      default: w_exp = 32'h0;
    endcase
  end

  assign w_mis = (alu_out != w_exp)
              || (alu_zero != (w_exp == 32'h0))
              || ((r_ctr == 4'b0010) && (alu_less != w_slt));

  always_comb begin
    w_err_next = r_err;
    if (w_load) begin
      w_err_next = 16'h0;
    end else if ((r_state == S_CHECK) && w_mis
                 && (r_err != 16'hFFFF)) begin
      w_err_next = r_err + 16'd1;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (r_start) w_next = S_DRIVE;
      end
      S_DRIVE: w_next = S_SETTLE;
      S_SETTLE: begin
        if (r_cnt == SET_LAST) w_next = S_CHECK;
      end
      S_CHECK: begin
        if (r_idx == LAST_IDX) begin
          w_next = S_DONE;
`ifdef ALU_BIST_STOP_ON_FAIL_EN
        end else if (w_mis) begin
          w_next = S_DONE;
`endif
        end else begin
          w_next = S_DRIVE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // start is registered, so a run begins one edge after it is sampled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start <= 1'b0;
      r_lfsr  <= SEED;
      r_a     <= 32'h0;
      r_b     <= 32'h0;
      r_ctr   <= 4'b0000;
      r_cnt   <= 4'h0;
      r_idx   <= 16'h0;
      r_err   <= 16'h0;
      r_fidx  <= 16'h0;
      r_fexp  <= 32'h0;
      r_fgot  <= 32'h0;
      r_first <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_start <= start && w_idle_like;
      r_err   <= w_err_next;
      r_busy  <= (w_next == S_DRIVE) || (w_next == S_SETTLE)
              || (w_next == S_CHECK);
      r_done  <= (w_next == S_DONE);
      r_pass  <= (w_next == S_DONE) && (w_err_next == 16'h0);
      if (w_load) begin
        r_lfsr  <= SEED;
        r_idx   <= 16'h0;
        r_fidx  <= 16'h0;
        r_fexp  <= 32'h0;
        r_fgot  <= 32'h0;
        r_first <= 1'b0;
      end
      if (r_state == S_DRIVE) begin
        r_lfsr <= w_step2;
        r_a    <= w_step1;
        r_b    <= w_step2;
        r_ctr  <= f_op(r_idx[2:0]);
        r_cnt  <= 4'h0;
      end
      if (r_state == S_SETTLE) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if (r_state == S_CHECK) begin
        if (w_mis && !r_first) begin
          r_first <= 1'b1;
          r_fidx  <= r_idx;
          r_fexp  <= w_exp;
          r_fgot  <= alu_out;
        end
        if (w_next == S_DRIVE) r_idx <= r_idx + 16'd1;
      end
    end
  end

  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_ctr   = r_ctr;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err;
  assign fail_idx  = r_fidx;
  assign fail_exp  = r_fexp;
  assign fail_got  = r_fgot;

endmodule

// File: tb/tb_alu_bist.sv
// tb_alu_bist: randomized fault-injection bench for alu_bist.
// Behavioural ALU with injectable faults plus a per-cycle timeline model.
module tb_alu_bist;

  localparam int N   = 8;
  localparam int S   = 1;
  localparam int VC  = 2 + S;
  localparam logic [31:0] SEED = 32'hACE1_2024;
  localparam logic [3:0] OPS [8] = '{4'b0000, 4'b1000, 4'b0001, 4'b0101,
                                     4'b0100, 4'b0111, 4'b0110, 4'b0010};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_ctr;
  logic        alu_less, alu_zero;
  logic        busy, done, pass;
  logic [15:0] err_count, fail_idx;
  logic [31:0] fail_exp, fail_got;

  int errors = 0;
  int checks = 0;

  int          mode = 0;
  logic [3:0]  f_op = 4'b0000;
  logic [31:0] f_mask = 32'h1;

  alu_bist #(.NUM_VECTORS(N), .SETTLE_CYCLES(S), .SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr),
    .alu_out(alu_out), .alu_less(alu_less), .alu_zero(alu_zero),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_idx(fail_idx),
    .fail_exp(fail_exp), .fail_got(fail_got)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    logic [31:0] y;
    y = x >> 1;
    if (x % 2 == 1) y = y ^ 32'h8020_0003;
    return y;
  endfunction

  function automatic logic [31:0] ref_out(input logic [31:0] a,
      input logic [31:0] b, input logic [3:0] op);
    case (op)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << (b % 32);
      4'b0101: return a >> (b % 32);
      4'b0100: return a ^ b;
      4'b0111: return a & b;
      4'b0110: return a | b;
      4'b0010: return ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  // The ALU under test, with the currently selected fault
  always_comb begin
    logic [31:0] t;
    t        = ref_out(alu_a, alu_b, alu_ctr);
    alu_zero = (t == 32'h0);
    alu_less = $signed(alu_a) < $signed(alu_b);
    alu_out  = t;
    if (mode == 1) alu_out = t & 32'hFFFF_FFFE;
    if (mode == 2) alu_less = 1'b0;
    if (mode == 3 && alu_ctr == f_op) alu_out = t ^ f_mask;
  end

  logic [31:0] ma [N];
  logic [31:0] mb [N];
  logic [3:0]  mc [N];
  bit          mm [N];
  logic [31:0] mexp [N];
  logic [31:0] mgot [N];
  int          nrun;
  int          tot_err;
  int          first_fail;

  logic [31:0] pa = 0, pb = 0;
  logic [3:0]  pc = 0;
  logic [31:0] pfe = 0, pfg = 0;
  int          perr = 0, pfi = 0;
  bit          pdone = 0, ppass = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic build_model();
    logic [31:0] x, good, got;
    bit gl, less, zero;
    x = SEED;
    tot_err = 0;
    first_fail = -1;
    nrun = N;
    for (int i = 0; i < N; i++) begin
      x = lfsr_next(x); ma[i] = x;
      x = lfsr_next(x); mb[i] = x;
      mc[i] = OPS[i % 8];
      good = ref_out(ma[i], mb[i], mc[i]);
      gl   = $signed(ma[i]) < $signed(mb[i]);
      got  = good;
      zero = (good == 0);
      less = gl;
      if (mode == 1) got = good & 32'hFFFF_FFFE;
      if (mode == 2) less = 1'b0;
      if (mode == 3 && mc[i] == f_op) got = good ^ f_mask;
      mm[i]   = (got != good) || (zero != (good == 0))
             || (mc[i] == 4'b0010 && less != gl);
      mexp[i] = good;
      mgot[i] = got;
    end
    for (int i = 0; i < N; i++) begin
      if (mm[i]) begin
        if (first_fail < 0) first_fail = i;
`ifdef ALU_BIST_STOP_ON_FAIL_EN
        if (nrun == N) nrun = i + 1;
`endif
      end
    end
    for (int i = 0; i < nrun; i++) if (mm[i]) tot_err++;
  endtask

  // One run: drive start, then compare every output after every edge
  task automatic do_run(input int hold, input int p1, input int p2,
                        input int rst_at, input bit pins);
    int len, c, v, e, fi;
    logic [3:0] seq [N];
    build_model();
    len = VC * nrun + 1;
    for (int k = 0; k <= len + 1; k++) begin
      start = (k < hold) || (k == p1) || (k == p2);
      @(posedge clk);
      #1;
      c = (k < 1) ? 0 : ((k - 1) / VC > nrun ? nrun : (k - 1) / VC);
      e = 0; fi = -1;
      for (int j = 0; j < c; j++) if (mm[j]) begin
        e++;
        if (fi < 0) fi = j;
      end
      if (k == 0) begin
        chk("busy", 32'(busy), 0);
        chk("done", 32'(done), 32'(pdone));
        chk("pass", 32'(pass), 32'(ppass));
        chk("err", 32'(err_count), perr);
        chk("fidx", 32'(fail_idx), pfi);
      end else begin
        chk("busy", 32'(busy), 32'(k < len));
        chk("done", 32'(done), 32'(k >= len));
        chk("pass", 32'(pass), 32'(k >= len && e == 0));
        chk("err", 32'(err_count), e);
        chk("fidx", 32'(fail_idx), fi < 0 ? 0 : fi);
        chk("fexp", fail_exp, fi < 0 ? 0 : mexp[fi]);
        chk("fgot", fail_got, fi < 0 ? 0 : mgot[fi]);
      end
      if (k < 2) begin
        chk("alu_a", alu_a, pa);
        chk("alu_b", alu_b, pb);
        chk("alu_ctr", 32'(alu_ctr), 32'(pc));
      end else begin
        v = (k - 2) / VC;
        if (v > nrun - 1) v = nrun - 1;
        chk("alu_a", alu_a, ma[v]);
        chk("alu_b", alu_b, mb[v]);
        chk("alu_ctr", 32'(alu_ctr), 32'(mc[v]));
        if ((k - 2) % VC == 0 && v < N) seq[v] = alu_ctr;
      end
      if (pins && k == 2) begin
        chk("pin_a0", alu_a, 32'h5670_9012);
        chk("pin_b0", alu_b, 32'h2B38_4809);
      end
      if (pins && k == 25) chk("pin_done25", 32'({done, busy}), 32'b10);
      if (k == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'({busy, done, pass}), 0);
        chk("rst_alu", alu_a | alu_b | 32'(alu_ctr), 0);
        chk("rst_res", 32'({err_count, fail_idx}), 0);
        chk("rst_fail", fail_exp | fail_got, 0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pa = 0; pb = 0; pc = 0; pfe = 0; pfg = 0;
        perr = 0; pfi = 0; pdone = 0; ppass = 0;
        return;
      end
    end
    start = 1'b0;
    if (pins) begin
      for (int i = 0; i < N; i++)
        chk("pin_ctr_seq", 32'(seq[i]), 32'(OPS[i]));
      chk("pin_golden", 32'({pass, err_count}), 32'h1_0000);
    end
    if (mode == 1 && tot_err > 0)
      chk("stuck_xor", fail_exp ^ fail_got, 32'h1);
    if (mode == 2 && tot_err > 0)
      chk("less_idx", 32'(fail_idx), 7);
    pa = ma[nrun-1]; pb = mb[nrun-1]; pc = mc[nrun-1];
    perr = tot_err; pdone = 1; ppass = (tot_err == 0);
    pfi = first_fail < 0 ? 0 : first_fail;
  endtask

  initial begin
    int hold, p1, p2;
    #12;
    chk("reset_flags", 32'({busy, done, pass}), 0);
    chk("reset_alu", alu_a | alu_b | 32'(alu_ctr), 0);
    chk("reset_err", 32'({err_count, fail_idx}), 0);
    chk("reset_fail", fail_exp | fail_got, 0);
    chk("model_lfsr", lfsr_next(SEED), 32'h5670_9012);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    mode = 0;
    do_run(1, -1, -1, -1, 1'b1);
    mode = 1;
    do_run(3, 7, 15, -1, 1'b0);
    mode = 2;
    do_run(1, -1, -1, -1, 1'b0);
    mode = 0;
    do_run(2, -1, -1, -1, 1'b0);
    mode = 1;
    do_run(1, -1, -1, 10, 1'b0);
    mode = 0;
    do_run(1, -1, -1, -1, 1'b1);
    mode = 3; f_op = OPS[2]; f_mask = 32'h0000_0100;
    do_run(1, -1, -1, -1, 1'b0);

    for (int r = 0; r < 20; r++) begin
      mode   = ($urandom_range(0, 3) == 0) ? 0 : 3;
      f_op   = OPS[$urandom_range(0, 7)];
      f_mask = $urandom;
      if (f_mask == 0) f_mask = 32'h8000_0000;
      hold = $urandom_range(1, 3);
      p1   = $urandom_range(3, VC * N);
      p2   = ($urandom_range(0, 1) == 1) ? $urandom_range(3, VC * N) : -1;
      do_run(hold, p1, p2, -1, 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
